// File: rtl/seq_det_pkg.sv
// Shared definitions for the parameterised serial sequence detector.
//   state_e   : detector FSM states
//   len_width : width needed to hold the values 0..max_len (clog2(max_len+1))
package seq_det_pkg;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,   // no valid configuration loaded
        S_FILL  = 2'd1,   // history holds fewer than len-1 bits
        S_ARMED = 2'd2    // history holds at least len-1 bits
    } state_e;

    function automatic int len_width(input int max_len);
        int w;
        w = 0;
        while ((1 << w) < (max_len + 1)) begin
            w = w + 1;
        end
        return w;
    endfunction

endpackage

// File: rtl/seq_det_cmp.sv
// Masked pattern comparator (purely combinational).
//   w           in  MAX_LEN : compare window, bit 0 = most recent sample
//   pattern_q   in  MAX_LEN : target pattern
//   care_mask_q in  MAX_LEN : 1 = compare this position, 0 = don't-care
//   len_q       in  LEN_W   : active length; positions >= len_q are ignored
//   match_raw   out 1       : every active, cared-for position matches
module seq_det_cmp #(
    parameter int MAX_LEN = 8,
    parameter int LEN_W   = 4
) (
    input  logic [MAX_LEN-1:0] w,
    input  logic [MAX_LEN-1:0] pattern_q,
    input  logic [MAX_LEN-1:0] care_mask_q,
    input  logic [LEN_W-1:0]   len_q,
    output logic               match_raw
);

    logic [MAX_LEN-1:0] bit_ok;

    genvar gi;
    generate
        for (gi = 0; gi < MAX_LEN; gi++) begin : g_bit
            assign bit_ok[gi] = (gi >= int'(len_q)) || !care_mask_q[gi] ||
                                (w[gi] == pattern_q[gi]);
        end
    endgenerate

    assign match_raw = &bit_ok;

endmodule

// File: rtl/seq_detector_param.sv
// Parameterised serial sequence detector with don't-care mask, run-time
// length, overlapping/non-overlapping modes and a saturating match counter.
//   clk         in  1       : clock, all state changes on its rising edge
//   rst         in  1       : asynchronous active-low reset
//   in          in  1       : serial data bit
//   in_valid    in  1       : qualifies in
//   cfg_load    in  1       : strobe latching pattern/care_mask/len/overlap
//   pattern     in  MAX_LEN : target, bit len-1 first in time, bit 0 last
//   care_mask   in  MAX_LEN : 1 = compare, 0 = don't-care
//   len         in  LEN_W   : active pattern length (1..MAX_LEN legal)
//   overlap     in  1       : 1 = overlapping detection
//   clr_count   in  1       : synchronous clear of match_count
//   out         out 1       : registered one-cycle match pulse
//   match_count out CNT_W   : saturating match count since last clear
//   armed       out 1       : FSM is in S_ARMED
//   cfg_err     out 1       : sticky illegal-configuration flag
module seq_detector_param
    import seq_det_pkg::*;
#(
    parameter int MAX_LEN = 8,
    parameter int CNT_W   = 8,
    // Derived; not meant to be overridden.
    parameter int LEN_W   = len_width(MAX_LEN)
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in,
    input  logic               in_valid,
    input  logic               cfg_load,
    input  logic [MAX_LEN-1:0] pattern,
    input  logic [MAX_LEN-1:0] care_mask,
    input  logic [LEN_W-1:0]   len,
    input  logic               overlap,
    input  logic               clr_count,
    output logic               out,
    output logic [CNT_W-1:0]   match_count,
    output logic               armed,
    output logic               cfg_err
);

    state_e             state_q, state_d;
    logic [MAX_LEN-2:0] hist_q, hist_d;
    logic [LEN_W-1:0]   fill_q, fill_d;
    logic [MAX_LEN-1:0] pattern_q, pattern_d;
    logic [MAX_LEN-1:0] care_mask_q, care_mask_d;
    logic [LEN_W-1:0]   len_q, len_d;
    logic               overlap_q, overlap_d;
    logic               out_q, out_d;
    logic [CNT_W-1:0]   count_q, count_d;
    logic               cfg_err_q, cfg_err_d;

    logic [MAX_LEN-1:0] w;
    logic [LEN_W-1:0]   fill_inc;
    logic               match_raw;
    logic               match;
    logic               sample;
    logic               cfg_legal;

    // The window is the stored history plus the bit arriving this cycle, so
    // a match is recognised on the very edge that samples the final bit.
    assign w         = {hist_q, in};
    assign cfg_legal = (len != '0) && (int'(len) <= MAX_LEN);
    // A simultaneous cfg_load discards the sample.
    assign sample    = in_valid && !cfg_load && (state_q != S_IDLE);
    assign match     = sample && (state_q == S_ARMED) && match_raw;
    assign fill_inc  = (fill_q == LEN_W'(MAX_LEN)) ? fill_q : fill_q + LEN_W'(1);

    seq_det_cmp #(
        .MAX_LEN (MAX_LEN),
        .LEN_W   (LEN_W)
    ) u_cmp (
        .w           (w),
        .pattern_q   (pattern_q),
        .care_mask_q (care_mask_q),
        .len_q       (len_q),
        .match_raw   (match_raw)
    );

    // State register (with all other flops of the block).
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            hist_q      <= '0;
            fill_q      <= '0;
            pattern_q   <= '0;
            care_mask_q <= '0;
            len_q       <= '0;
            overlap_q   <= 1'b0;
            out_q       <= 1'b0;
            count_q     <= '0;
            cfg_err_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            hist_q      <= hist_d;
            fill_q      <= fill_d;
            pattern_q   <= pattern_d;
            care_mask_q <= care_mask_d;
            len_q       <= len_d;
            overlap_q   <= overlap_d;
            out_q       <= out_d;
            count_q     <= count_d;
            cfg_err_q   <= cfg_err_d;
        end
    end

    // Next-state logic.
    always_comb begin
        state_d = state_q;
        if (cfg_load) begin
            if (!cfg_legal) begin
                state_d = S_IDLE;
            end else if (len == LEN_W'(1)) begin
                state_d = S_ARMED;
            end else begin
                state_d = S_FILL;
            end
        end else if (sample) begin
            if (match && !overlap_q) begin
                // A one-bit pattern needs no history, so it re-arms at once.
                state_d = (len_q == LEN_W'(1)) ? S_ARMED : S_FILL;
            end else if ((state_q == S_FILL) && (fill_inc == len_q - LEN_W'(1))) begin
                state_d = S_ARMED;
            end
        end
    end

    // Datapath next values.
    always_comb begin
        hist_d      = hist_q;
        fill_d      = fill_q;
        pattern_d   = pattern_q;
        care_mask_d = care_mask_q;
        len_d       = len_q;
        overlap_d   = overlap_q;
        cfg_err_d   = cfg_err_q;
        out_d       = match;
        count_d     = count_q;

        if (sample) begin
            hist_d = w[MAX_LEN-2:0];
            fill_d = (match && !overlap_q) ? '0 : fill_inc;
        end

        if (match && (count_q != {CNT_W{1'b1}})) begin
            count_d = count_q + CNT_W'(1);
        end
        if (clr_count) begin
            count_d = '0;
        end

        if (cfg_load) begin
            if (cfg_legal) begin
                pattern_d   = pattern;
                care_mask_d = care_mask;
                len_d       = len;
                overlap_d   = overlap;
                hist_d      = '0;
                fill_d      = '0;
                count_d     = '0;
                cfg_err_d   = 1'b0;
            end else begin
                cfg_err_d   = 1'b1;
            end
        end
    end

    // Outputs.
    always_comb begin
        armed       = (state_q == S_ARMED);
        out         = out_q;
        match_count = count_q;
        cfg_err     = cfg_err_q;
    end

endmodule

// File: tb/tb_seq_detector_param.sv
module tb_seq_detector_param;
    import seq_det_pkg::*;

    localparam int MAX_LEN = 8;
    localparam int CNT_W   = 2;
    localparam int LEN_W   = len_width(MAX_LEN);

    logic               clk = 1'b0;
    logic               rst;
    logic               din;
    logic               in_valid;
    logic               cfg_load;
    logic [MAX_LEN-1:0] pattern;
    logic [MAX_LEN-1:0] care_mask;
    logic [LEN_W-1:0]   len;
    logic               overlap;
    logic               clr_count;
    logic               dout;
    logic [CNT_W-1:0]   match_count;
    logic               armed;
    logic               cfg_err;

    int n_checks = 0;
    int n_bad    = 0;

    always #5 clk = ~clk;

    seq_detector_param #(
        .MAX_LEN (MAX_LEN),
        .CNT_W   (CNT_W)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .in          (din),
        .in_valid    (in_valid),
        .cfg_load    (cfg_load),
        .pattern     (pattern),
        .care_mask   (care_mask),
        .len         (len),
        .overlap     (overlap),
        .clr_count   (clr_count),
        .out         (dout),
        .match_count (match_count),
        .armed       (armed),
        .cfg_err     (cfg_err)
    );

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic load(input int l, input logic [MAX_LEN-1:0] p,
                        input logic [MAX_LEN-1:0] m, input logic ov);
        cfg_load  = 1'b1;
        len       = LEN_W'(l);
        pattern   = p;
        care_mask = m;
        overlap   = ov;
        @(posedge clk);
        #1;
        cfg_load = 1'b0;
        in_valid = 1'b0;
        $display("load len=%0d pat=%b mask=%b ov=%0b -> armed=%0b err=%0b",
                 l, p, m, ov, armed, cfg_err);
    endtask

    task automatic send_bit(input logic b, input logic clr);
        din       = b;
        in_valid  = 1'b1;
        clr_count = clr;
        @(posedge clk);
        #1;
        in_valid  = 1'b0;
        clr_count = 1'b0;
        $display("bit in=%0b clr=%0b -> out=%0b cnt=%0d armed=%0b",
                 b, clr, dout, match_count, armed);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) begin
            @(posedge clk);
        end
        #1;
    endtask

    logic [4:0] bits5;
    logic [4:0] exp5;

    initial begin
        rst = 1'b0; din = 1'b0; in_valid = 1'b0; cfg_load = 1'b0;
        pattern = '0; care_mask = '0; len = '0; overlap = 1'b0; clr_count = 1'b0;
        idle(2);
        check_eq("rst_out", dout, 0);
        check_eq("rst_armed", armed, 0);
        check_eq("rst_err", cfg_err, 0);
        check_eq("rst_cnt", match_count, 0);
        rst = 1'b1;
        idle(1);

        // len=5 masked pattern; upper pattern/mask bits must be ignored
        load(5, 8'b11110100, 8'b11111101, 1'b0);
        check_eq("l5_armed0", armed, 0);
        bits5 = 5'b10110; exp5 = 5'b00001;
        for (int i = 4; i >= 0; i--) begin
            send_bit(bits5[i], 1'b0);
            check_eq("l5a_out", dout, exp5[i]);
            if (i == 1) check_eq("l5a_armed", armed, 1);
        end
        check_eq("l5a_cnt", match_count, 1);
        check_eq("l5a_rearm", armed, 0);
        idle(1);
        check_eq("l5_idle_out", dout, 0);
        bits5 = 5'b10100;
        for (int i = 4; i >= 0; i--) begin
            send_bit(bits5[i], 1'b0);
            check_eq("l5b_out", dout, exp5[i]);
        end
        check_eq("l5b_cnt", match_count, 2);

        // len=3 pattern 101, overlapping then non-overlapping
        load(3, 8'b101, 8'b111, 1'b1);
        check_eq("l3_cnt_clr", match_count, 0);
        bits5 = 5'b10101; exp5 = 5'b00101;
        for (int i = 4; i >= 0; i--) begin
            send_bit(bits5[i], 1'b0);
            check_eq("ov1_out", dout, exp5[i]);
        end
        check_eq("ov1_cnt", match_count, 2);
        load(3, 8'b101, 8'b111, 1'b0);
        exp5 = 5'b00100;
        for (int i = 4; i >= 0; i--) begin
            send_bit(bits5[i], 1'b0);
            check_eq("ov0_out", dout, exp5[i]);
        end
        check_eq("ov0_cnt", match_count, 1);

        // illegal configurations
        load(0, 8'b101, 8'b111, 1'b0);
        check_eq("len0_err", cfg_err, 1);
        check_eq("len0_armed", armed, 0);
        send_bit(1'b1, 1'b0);
        send_bit(1'b1, 1'b0);
        check_eq("len0_armed_hold", armed, 0);
        check_eq("len0_out", dout, 0);
        load(9, 8'b101, 8'b111, 1'b0);
        check_eq("len9_err", cfg_err, 1);
        load(3, 8'b101, 8'b111, 1'b1);
        check_eq("legal_err_clr", cfg_err, 0);

        // len=1: direct arm, saturation at 3, clear beats match
        load(1, 8'b1, 8'b1, 1'b1);
        check_eq("l1_armed", armed, 1);
        for (int i = 1; i <= 5; i++) begin
            send_bit(1'b1, 1'b0);
            check_eq("sat_out", dout, 1);
            check_eq("sat_cnt", match_count, (i < 3) ? i : 3);
        end
        send_bit(1'b1, 1'b1);
        check_eq("clr_out", dout, 1);
        check_eq("clr_cnt", match_count, 0);
        send_bit(1'b0, 1'b0);
        check_eq("l1_zero_out", dout, 0);

        // cfg_load with in_valid in the same cycle: sample discarded
        din = 1'b1; in_valid = 1'b1;
        load(2, 8'b11, 8'b11, 1'b0);
        check_eq("cfgv_armed", armed, 0);
        send_bit(1'b1, 1'b0);
        check_eq("cfgv_out1", dout, 0);
        check_eq("cfgv_armed1", armed, 1);
        idle(3);
        check_eq("hold_armed", armed, 1);
        check_eq("hold_out", dout, 0);
        send_bit(1'b1, 1'b0);
        check_eq("cfgv_out2", dout, 1);

        // asynchronous reset mid-stream
        load(1, 8'b1, 8'b1, 1'b1);
        send_bit(1'b1, 1'b0);
        check_eq("pre_rst_out", dout, 1);
        check_eq("pre_rst_cnt", match_count, 1);
        rst = 1'b0;
        #1;
        check_eq("arst_out", dout, 0);
        check_eq("arst_armed", armed, 0);
        check_eq("arst_cnt", match_count, 0);
        idle(1);
        rst = 1'b1;
        send_bit(1'b1, 1'b0);
        check_eq("post_rst_out", dout, 0);
        check_eq("post_rst_armed", armed, 0);

        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

endmodule
